// File: rtl/io_intr_ctrl.sv
// -----------------------------------------------------------------------------
// io_intr_ctrl
// Interrupt controller between the memory-mapped IO devices (timer, keys,
// switches) and the pipeline's interrupt entry logic. Level IRQ lines are
// masked by a software IMR and a global enable (GIE). One source is chosen by
// fixed or rotating priority and carried through a request / acknowledge /
// end-of-interrupt handshake, so the pipeline sees one interrupt at a time
// with a stable vector.
//
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_rst_n  asynchronous active-low reset
//   i_irq    [NSRC] level IRQ lines (index 0 timer, 1 keys, 2 switches)
//   i_abus   [BITS] address from the memory stage
//   i_din    [BITS] write data
//   i_we     write enable
//   o_dout   [BITS] read data (CTRL / STAT), 0 for any other address
//   o_intr   interrupt request to the pipeline
//   i_inta   one-cycle acknowledge (interrupt taken)
//   o_vec    [3] index of the selected / in-service source
//   i_eoi    one-cycle end-of-interrupt
//
// CTRL: [NSRC-1:0] IMR, [31] GIE.
// STAT: [NSRC-1:0] raw IRQ, [10:8] VEC, [30] in-service, [31] pending.
// -----------------------------------------------------------------------------
module io_intr_ctrl #(
  parameter int              BITS      = 32,
  parameter int              NSRC      = 3,
  parameter int              ROTATE    = 0,
  parameter logic [BITS-1:0] CTRL_ADDR = 32'hFFFFF200,
  parameter logic [BITS-1:0] STAT_ADDR = 32'hFFFFF204
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NSRC-1:0] i_irq,
  input  logic [BITS-1:0] i_abus,
  input  logic [BITS-1:0] i_din,
  input  logic            i_we,
  output logic [BITS-1:0] o_dout,
  output logic            o_intr,
  input  logic            i_inta,
  output logic [2:0]      o_vec,
  input  logic            i_eoi
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_intr;
  logic [2:0]      r_vec;
  logic [2:0]      r_ptr;
  logic [NSRC-1:0] r_imr;
  logic            r_gie;

  logic [NSRC-1:0] w_elig;
  logic [2:0]      w_start;
  logic [2:0]      w_sel;
  logic [2:0]      w_ptr_nxt;
  logic            w_ctrl_wr;
  logic [BITS-1:0] w_dout;
  logic            w_unused_din;

  // First eligible source found searching upward from 'start', wrapping at
  // NSRC-1 -> 0. Returns 0 when nothing is eligible.
  function automatic logic [2:0] f_select(input logic [NSRC-1:0] elig,
                                          input logic [2:0]      start);
    logic [2:0] pick;
    logic       found;
    logic [3:0] idx;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx = {1'b0, start} + 4'(k);
      idx = (idx >= 4'(NSRC)) ? (idx - 4'(NSRC)) : idx;
      if (!found && elig[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end else begin
        pick  = pick;
        found = found;
      end
    end
    return pick;
  endfunction

  assign w_elig    = i_irq & r_imr & {NSRC{r_gie}};
  // Fixed priority is a rotating search that always starts at index 0.
  assign w_start   = (ROTATE != 0) ? r_ptr : 3'd0;
  assign w_sel     = f_select(w_elig, w_start);
  assign w_ptr_nxt = (r_vec == 3'(NSRC - 1)) ? 3'd0 : (r_vec + 3'd1);
  assign w_ctrl_wr = i_we && (i_abus == CTRL_ADDR);

  // Data bits that have no backing register in CTRL.
  assign w_unused_din = ^i_din[BITS-2:NSRC];

  // CTRL register: interrupt mask and global enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_imr <= '0;
      r_gie <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_imr <= i_din[NSRC-1:0];
      r_gie <= i_din[31];
    end else begin
      r_imr <= r_imr;
      r_gie <= r_gie;
    end
  end

  // Handshake FSM; INTR is registered alongside the state so it is glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_intr  <= 1'b0;
      r_vec   <= 3'd0;
      r_ptr   <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_vec <= w_sel;
          if (w_elig != '0) begin
            r_state <= ST_PEND;
            r_intr  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_intr  <= 1'b0;
          end
        end
        ST_PEND: begin
          // INTA beats any same-cycle mask change: the vector seen during
          // the acknowledge cycle is the one that goes into service.
          if (i_inta) begin
            r_state <= ST_SERV;
            r_intr  <= 1'b0;
          end else if (w_elig == '0) begin
            r_state <= ST_IDLE;
            r_intr  <= 1'b0;
            r_vec   <= w_sel;
          end else begin
            r_state <= ST_PEND;
            r_intr  <= 1'b1;
            r_vec   <= w_sel;
          end
        end
        ST_SERV: begin
          r_intr <= 1'b0;
          if (i_eoi) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_ptr_nxt;
          end else begin
            r_state <= ST_SERV;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end

  // Read mux, combinational from the address; reads have no side effects.
  always_comb begin
    w_dout = '0;
    if (i_abus == CTRL_ADDR) begin
      w_dout[31]       = r_gie;
      w_dout[NSRC-1:0] = r_imr;
    end else if (i_abus == STAT_ADDR) begin
      w_dout[31]       = r_intr;
      w_dout[30]       = (r_state == ST_SERV);
      w_dout[10:8]     = r_vec;
      w_dout[NSRC-1:0] = i_irq;
    end else begin
      w_dout = '0;
    end
  end

  assign o_dout = w_dout;
  assign o_intr = r_intr;
  assign o_vec  = r_vec;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_io_intr_ctrl
// Drives a fixed-priority and a rotating-priority instance with the same
// stimulus and compares both against a behavioural model of the controller.
// -----------------------------------------------------------------------------
module tb_io_intr_ctrl;

  localparam logic [31:0] CTRL_A = 32'hFFFFF200;
  localparam logic [31:0] STAT_A = 32'hFFFFF204;
  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_SERV = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  irq   = 3'b000;
  logic [31:0] abus  = 32'h0;
  logic [31:0] din   = 32'h0;
  logic        we    = 1'b0;
  logic        inta  = 1'b0;
  logic        eoi   = 1'b0;

  logic        intr0, intr1;
  logic [2:0]  vec0, vec1;
  logic [31:0] dout0, dout1;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = fixed priority, 1 = rotating priority
  int m_mode[2];
  int m_vec[2];
  int m_ptr[2];
  int m_imr[2];
  int m_gie[2];

  io_intr_ctrl #(.ROTATE(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_abus(abus), .i_din(din),
    .i_we(we), .o_dout(dout0), .o_intr(intr0), .i_inta(inta), .o_vec(vec0),
    .i_eoi(eoi)
  );

  io_intr_ctrl #(.ROTATE(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_abus(abus), .i_din(din),
    .i_we(we), .o_dout(dout1), .o_intr(intr1), .i_inta(inta), .o_vec(vec1),
    .i_eoi(eoi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Lowest eligible index at or after 'start', wrapping modulo 3.
  function automatic int pick(input int elig, input int start);
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (start + k) % 3;
      if (((elig >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_mode[r] = M_IDLE;
      m_vec[r]  = 0;
      m_ptr[r]  = 0;
      m_imr[r]  = 0;
      m_gie[r]  = 0;
    end
  endtask

  task automatic model_step();
    int elig;
    int sel;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int r = 0; r < 2; r++) begin
      elig = (m_gie[r] != 0) ? (int'(irq) & m_imr[r]) : 0;
      sel  = pick(elig, (r == 1) ? m_ptr[r] : 0);
      case (m_mode[r])
        M_IDLE: begin
          m_vec[r] = sel;
          if (elig != 0) m_mode[r] = M_PEND;
        end
        M_PEND: begin
          if (inta) m_mode[r] = M_SERV;
          else begin
            m_vec[r] = sel;
            if (elig == 0) m_mode[r] = M_IDLE;
          end
        end
        default: begin
          if (eoi) begin
            m_mode[r] = M_IDLE;
            m_ptr[r]  = (m_vec[r] + 1) % 3;
          end
        end
      endcase
      if (we && abus == CTRL_A) begin
        m_imr[r] = int'(din[2:0]);
        m_gie[r] = int'(din[31]);
      end
    end
  endtask

  function automatic logic [31:0] exp_dout(input int r);
    logic [31:0] d;
    d = 32'h0;
    if (abus == CTRL_A) begin
      d[31]  = (m_gie[r] != 0);
      d[2:0] = 3'(m_imr[r]);
    end else if (abus == STAT_A) begin
      d[31]   = (m_mode[r] == M_PEND);
      d[30]   = (m_mode[r] == M_SERV);
      d[10:8] = 3'(m_vec[r]);
      d[2:0]  = irq;
    end
    return d;
  endfunction

  task automatic check_all();
    chk("intr_fixed", {31'h0, intr0}, {31'h0, m_mode[0] == M_PEND});
    chk("intr_rot",   {31'h0, intr1}, {31'h0, m_mode[1] == M_PEND});
    chk("vec_fixed",  {29'h0, vec0}, 32'(m_vec[0]));
    chk("vec_rot",    {29'h0, vec1}, 32'(m_vec[1]));
    chk("dout_fixed", dout0, exp_dout(0));
    chk("dout_rot",   dout1, exp_dout(1));
  endtask

  // One clock: advance model on the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed away from the clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    cyc();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic write_ctrl(input logic [31:0] val);
    we = 1'b1; abus = CTRL_A; din = val;
    cyc();
    we = 1'b0; din = 32'h0;
  endtask

  int exp_seq[4] = '{0, 1, 2, 0};

  initial begin
    model_reset();
    cyc();
    cyc();
    chk("reset_intr", {31'h0, intr0}, 32'h0);
    chk("reset_vec",  {29'h0, vec0}, 32'h0);
    #2 rst_n = 1'b1;

    // Single source through the whole handshake
    write_ctrl(32'h80000007);
    chk("ctrl_readback", dout0, 32'h80000007);
    irq = 3'b010; abus = STAT_A;
    cyc();
    chk("tp1_intr", {31'h0, intr0}, 32'h1);
    chk("tp1_vec",  {29'h0, vec0}, 32'h1);
    inta = 1'b1; cyc(); inta = 1'b0;
    chk("tp1_inta_intr", {31'h0, intr0}, 32'h0);
    chk("tp1_inserv", {31'h0, dout0[30]}, 32'h1);
    irq = 3'b000; eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc();
    chk("tp1_stat_clear", dout0, 32'h0);

    // Fixed priority, re-request after a one-cycle gap
    irq = 3'b110;
    cyc();
    chk("tp2_vec", {29'h0, vec0}, 32'h1);
    inta = 1'b1; cyc(); inta = 1'b0;
    eoi = 1'b1; cyc(); eoi = 1'b0;
    chk("tp2_gap", {31'h0, intr0}, 32'h0);
    cyc();
    chk("tp2_again_intr", {31'h0, intr0}, 32'h1);
    chk("tp2_again_vec",  {29'h0, vec0}, 32'h1);
    inta = 1'b1; cyc(); inta = 1'b0;
    irq = 3'b000; eoi = 1'b1; cyc(); eoi = 1'b0;

    // Rotating priority sequence from reset
    async_reset();
    write_ctrl(32'h80000007);
    irq = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 4 && !intr1; t++) cyc();
      chk("rot_wait", {31'h0, intr1}, 32'h1);
      chk("rot_vec", {29'h0, vec1}, 32'(exp_seq[k]));
      inta = 1'b1; cyc(); inta = 1'b0;
      eoi = 1'b1; cyc(); eoi = 1'b0;
    end
    irq = 3'b000;
    cyc();

    // Masking the pending source withdraws the request; late INTA ignored
    async_reset();
    write_ctrl(32'h80000007);
    irq = 3'b100;
    cyc();
    chk("mask_pend_vec", {29'h0, vec0}, 32'h2);
    write_ctrl(32'h80000003);
    chk("mask_write_edge", {31'h0, intr0}, 32'h1);
    abus = STAT_A;
    cyc();
    chk("mask_intr_fall", {31'h0, intr0}, 32'h0);
    inta = 1'b1; cyc(); inta = 1'b0;
    chk("mask_inta_ign", {31'h0, dout0[30]}, 32'h0);

    // INTA together with a masking write: INTA wins with the prior vector
    write_ctrl(32'h80000007);
    irq = 3'b010;
    cyc();
    inta = 1'b1; we = 1'b1; abus = CTRL_A; din = 32'h80000005;
    cyc();
    inta = 1'b0; we = 1'b0; abus = STAT_A;
    chk("inta_vs_mask_vec", {29'h0, vec0}, 32'h1);
    cyc();
    chk("inta_vs_mask_serv", {31'h0, dout0[30]}, 32'h1);
    eoi = 1'b1; cyc(); eoi = 1'b0;

    // No nesting; reset during service
    write_ctrl(32'h80000007);
    irq = 3'b100;
    cyc();
    inta = 1'b1; cyc(); inta = 1'b0;
    irq = 3'b101;
    for (int t = 0; t < 3; t++) begin
      cyc();
      chk("serv_no_nest", {31'h0, intr0}, 32'h0);
    end
    eoi = 1'b1; cyc(); eoi = 1'b0;
    cyc();
    chk("serv_next_intr", {31'h0, intr0}, 32'h1);
    chk("serv_next_vec",  {29'h0, vec0}, 32'h0);
    inta = 1'b1; cyc(); inta = 1'b0;
    abus = CTRL_A;
    async_reset();
    chk("rst_ctrl_read", dout0, 32'h0);
    for (int t = 0; t < 3; t++) begin
      cyc();
      chk("rst_no_intr", {31'h0, intr0}, 32'h0);
    end

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq = 3'($urandom_range(0, 7));
      we  = ($urandom_range(0, 9) == 0);
      din = $urandom;
      if ($urandom_range(0, 3) != 0) din[31] = 1'b1;
      case ($urandom_range(0, 3))
        0, 1:    abus = CTRL_A;
        2:       abus = STAT_A;
        default: abus = $urandom;
      endcase
      if (we) abus = CTRL_A;
      inta = ($urandom_range(0, 3) == 0);
      eoi  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 399) == 0) begin
        we = 1'b0; inta = 1'b0; eoi = 1'b0;
        async_reset();
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_intr_ctrl.md
# io_intr_ctrl

Interrupt controller that sits between the memory-mapped IO devices (keys, switches, timer) and the pipeline's interrupt entry logic. It collects per-device IRQ lines and applies a software-programmed mask and global enable. It selects one source by fixed or rotating priority and sequences it through a request/acknowledge/end-of-interrupt handshake, so the pipeline sees exactly one interrupt at a time with a stable vector.

## Interface
- BITS, 32, data/address bus width
- NSRC, 3, number of IRQ sources (max 8); index 0 = timer, 1 = keys, 2 = switches
- ROTATE, 0, 0 = fixed priority (lowest index wins); 1 = rotating priority
- CTRL_ADDR, 32'hFFFFF200, mask/enable register address
- STAT_ADDR, 32'hFFFFF204, status register address (read-only)

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset
- IRQ  in  NSRC  level IRQ lines (device Ready && IE)
- ABUS  in  BITS  address from memory stage
- DIN  in  BITS  write data
- WE  in  1  write enable
- DOUT  out  BITS  read data; 0 when ABUS matches neither register
- INTR  out  1  interrupt request to pipeline
- INTA  in  1  one-cycle acknowledge from pipeline (interrupt taken)
- VEC  out  3  index of selected source; valid while INTR or in service
- EOI  in  1  one-cycle end-of-interrupt (return-from-interrupt retired)

## Operation
- CTRL register: bits [NSRC-1:0] IMR (1 = enabled), bit 31 GIE; all other bits read 0, writes ignored. Written when WE && ABUS==CTRL_ADDR.
- STAT register: [NSRC-1:0] raw IRQ, [10:8] VEC, bit 30 in-service, bit 31 pending. Writes ignored.
- DOUT is combinational from ABUS; reads have no side effects.
- eligible = IRQ & IMR, gated by GIE.
- Priority: ROTATE=0 selects the lowest eligible index. ROTATE=1 searches upward from pointer PTR with wrap at NSRC-1 -> 0. PTR resets to 0 and loads (serviced index + 1) mod NSRC on EOI.
- FSM states:
  - IDLE: eligible != 0 -> PEND.
  - PEND: INTA -> SERV; eligible == 0 (source withdrew, masked, or GIE cleared) -> IDLE; else stay.
  - SERV: EOI -> IDLE; all IRQ/mask changes ignored for state.
- INTR = (state == PEND), decoded from the state register only (glitch-free).
- VEC register: loads the selected index every cycle in IDLE and PEND; frozen in SERV.
- INTA outside PEND and EOI outside SERV are ignored and have no effect.
- No nesting: a higher-priority IRQ arriving in SERV waits for EOI.
- Reset: state IDLE, IMR=0, GIE=0, PTR=0, VEC=0, INTR=0, DOUT reflects reset registers.

## Timing
- IRQ rising before edge k (eligible) -> state PEND and INTR=1 after edge k. Latency is one cycle.
- INTA sampled at edge m in PEND -> SERV after edge m. The VEC value captured is the one visible during cycle m. INTR drops after edge m.
- EOI sampled at edge n -> IDLE after n. If a source is still eligible, PEND again after n+1: a minimum 1-cycle INTR gap between interrupts.
- Simultaneous INTA and a CTRL write that masks the selected source, in PEND: INTA wins, SERV with prior VEC.
- A CTRL write takes effect on eligibility the cycle after the write edge.
- Simultaneous EOI and a new IRQ: EOI completes; the new IRQ is handled from IDLE.
- RST asserted mid-SERV or mid-PEND: immediate return to reset values, independent of CLK. On deassertion, IDLE with GIE=0, so no INTR until software re-enables.

## Test plan
- Reset, write CTRL=32'h80000007, pulse IRQ[1] high -> INTR=1 one cycle later, VEC=1. INTA -> INTR=0, STAT bit30=1. EOI -> STAT=0 with IRQ dropped.
- IRQ=3'b110 held, ROTATE=0 -> VEC=1. After EOI with IRQ still 3'b110 -> INTR after 1-cycle gap, VEC=1 again.
- ROTATE=1, IRQ=3'b111 held, three INTA/EOI rounds -> VEC sequence 0,1,2, then 0.
- IRQ[2] in PEND, write CTRL=32'h80000003 before INTA -> INTR falls the cycle after the write, state IDLE. INTA then -> ignored.
- In SERV (VEC=2) raise IRQ[0] -> INTR stays 0 until EOI, then INTR with VEC=0. Pulse RST low mid-SERV -> INTR=0, VEC=0, DOUT at CTRL_ADDR = 0 immediately.
